// File: rtl/fifo_control_pkg.sv
// fifo_control_pkg: shared FSM encoding and default widths for the FIFO control slice
package fifo_control_pkg;
  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 10;
  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;
endpackage

// File: rtl/fifo_control_ptr.sv
// fifo_ptr: wrapping memory address pointer advanced by an increment enable
module fifo_ptr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  // Natural W-bit rollover gives the depth-1 -> 0 wrap
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
endmodule

// File: rtl/fifo_control.sv
// fifo_control: push/pop to memory strobes, addresses, occupancy flags and error FSM
module fifo_control
  import fifo_control_pkg::*;
#(
  parameter int address_width = DEF_ADDRESS_WIDTH,
  parameter int data_width    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [address_width-1:0] umbral_almost_full,
  input  logic [address_width-1:0] umbral_almost_empty,
  input  logic                     push,
  input  logic                     pop,
  output logic                     wrmem_enable,
  output logic                     rdmem_enable,
  output logic [address_width-1:0] wr_addr,
  output logic [address_width-1:0] rd_addr,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     error,
  output logic [2:0]               state
);
  localparam logic [address_width:0] depth = {1'b1, {address_width{1'b0}}};
  if (data_width < 1) begin : g_bad_width
    $error("data_width must be positive");
  end
  state_t st, st_nxt;
  logic [address_width:0] count, count_nxt;
  logic [address_width-1:0] th_af, th_ae;
  logic op, push_ok, pop_ok, fault;
  assign full = count == depth;
  assign empty = count == '0;
  assign almost_full = count >= {1'b0, th_af};
  assign almost_empty = !empty && count <= {1'b0, th_ae};
  assign error = st == ST_ERROR;
  assign state = st;
  assign wrmem_enable = push_ok;
  assign rdmem_enable = pop_ok;
  // Qualify requests; a full FIFO still takes a push when a pop frees a slot
  always_comb begin
    op = st == ST_IDLE || st == ST_ACTIVE;
    pop_ok = op && pop && !empty;
    push_ok = op && push && (!full || pop_ok);
    fault = op && ((push && full && !pop) || (pop && empty));
    count_nxt = count + (address_width+1)'(push_ok) - (address_width+1)'(pop_ok);
  end
  // Next state: errors win over init, otherwise occupancy picks IDLE/ACTIVE
  always_comb begin
    st_nxt = st;
    case (st)
      ST_RESET: st_nxt = ST_INIT;
      ST_INIT:  st_nxt = init ? ST_INIT : (count == '0 ? ST_IDLE : ST_ACTIVE);
      ST_ERROR: st_nxt = init ? ST_INIT : ST_ERROR;
      default:  st_nxt = fault ? ST_ERROR : init ? ST_INIT : (count_nxt == '0 ? ST_IDLE : ST_ACTIVE);
    endcase
  end
  // State, occupancy and thresholds; thresholds follow the inputs while init is held
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= ST_RESET;
      count <= '0;
      th_af <= '1;
      th_ae <= address_width'(1);
    end else begin
      st <= st_nxt;
      count <= count_nxt;
      if (init && st != ST_RESET) begin
        th_af <= umbral_almost_full;
        th_ae <= umbral_almost_empty;
      end
    end
  fifo_ptr #(.W(address_width)) u_wr_ptr (.clk(clk), .reset(reset), .inc(push_ok), .ptr(wr_addr));
  fifo_ptr #(.W(address_width)) u_rd_ptr (.clk(clk), .reset(reset), .inc(pop_ok), .ptr(rd_addr));
endmodule
